// File: rtl/iob_aoi_sweep.sv
// Sweep/capture stage for the iob_aoi gate: walks all 16 input vectors, holds each
// for SETTLE_CYCLES, and compares y against ~((a&b)|(c&d)).
module iob_aoi_sweep #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       arst_i,
    input  logic       cke_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic       y_i,
    output logic       a_o,
    output logic       b_o,
    output logic       c_o,
    output logic       d_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       pass_o,
    output logic [4:0] err_cnt_o,
    output logic       first_err_vld_o,
    output logic [3:0] first_err_vec_o
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam logic [7:0] RELOAD = 8'(SETTLE_CYCLES - 1);

    state_t     state;
    logic [3:0] vec;
    logic [7:0] cnt;
    logic       busy;
    logic       done;
    logic [4:0] err_cnt;
    logic       first_vld;
    logic [3:0] first_vec;

    logic expected;
    logic mismatch;
    logic accept;

    assign expected = ~((vec[0] & vec[1]) | (vec[2] & vec[3]));
    assign mismatch = (y_i != expected);
    assign accept   = start_i & ~abort_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state     <= IDLE;
            vec       <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err_cnt   <= '0;
            first_vld <= 1'b0;
            first_vec <= '0;
        end else if (cke_i) begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state     <= RUN;
                        vec       <= '0;
                        cnt       <= RELOAD;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        err_cnt   <= '0;
                        first_vld <= 1'b0;
                        first_vec <= '0;
                    end
                end
                RUN: begin
                    // Abort freezes vec and the error registers for inspection.
                    if (abort_i) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + 5'd1;
                            if (!first_vld) begin
                                first_vld <= 1'b1;
                                first_vec <= vec;
                            end
                        end
                        if (vec == 4'hF) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            vec <= vec + 4'd1;
                            cnt <= RELOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_o             = vec[0];
    assign b_o             = vec[1];
    assign c_o             = vec[2];
    assign d_o             = vec[3];
    assign busy_o          = busy;
    assign done_o          = done;
    assign pass_o          = done & (err_cnt == 5'd0);
    assign err_cnt_o       = err_cnt;
    assign first_err_vld_o = first_vld;
    assign first_err_vec_o = first_vec;

endmodule

// File: doc/iob_aoi_sweep.md
# iob_aoi_sweep

Self-checking stimulus/capture stage for the `iob_aoi` gate. It drives the gate's four inputs through all 16 input combinations. It holds each vector for a programmable settle time, samples the gate's output `y` and compares it against the expected and-or-invert function `~((a&b)|(c&d))`. It reports a pass/fail verdict, the mismatch count and the first failing vector. It sits on both sides of `iob_aoi`: its `a_o`..`d_o` feed `a_i`..`d_i`, and the gate's `y_o` returns on `y_i`.

## Interface
- `SETTLE_CYCLES`, default 2: cycles each vector is held before sampling; legal range 1..255.
- `clk_i`  in  1  system clock; all state updates on the rising edge.
- `arst_i`  in  1  asynchronous reset, active-high.
- `cke_i`  in  1  clock enable; when low, all registers hold.
- `start_i`  in  1  single-cycle request to begin a sweep.
- `abort_i`  in  1  single-cycle request to stop a running sweep.
- `y_i`  in  1  output of the gate under test.
- `a_o`  out  1  gate input a = `vec[0]`.
- `b_o`  out  1  gate input b = `vec[1]`.
- `c_o`  out  1  gate input c = `vec[2]`.
- `d_o`  out  1  gate input d = `vec[3]`.
- `busy_o`  out  1  high while the sweep is running.
- `done_o`  out  1  high after a completed sweep, until the next accepted start.
- `pass_o`  out  1  `done_o & (err_cnt_o == 0)`.
- `err_cnt_o`  out  5  number of mismatching vectors, 0..16; no saturation needed.
- `first_err_vld_o`  out  1  at least one mismatch recorded in the current or last sweep.
- `first_err_vec_o`  out  4  vector index of the first mismatch.

## Operation
- Registers: `vec[3:0]`, `cnt[7:0]`, `state`, plus the error registers listed above.
- `a_o`..`d_o` come directly from `vec` (registered outputs, no glitches).
- States and transitions:
  - IDLE: `busy_o` = 0. On `start_i` and not `abort_i`: clear `vec`, `err_cnt_o`, `first_err_vld_o` and `first_err_vec_o`; load `cnt` = SETTLE_CYCLES−1; go to RUN.
  - RUN: `busy_o` = 1.
    - `abort_i` has highest priority: go to IDLE with `vec` and the error registers frozen and `done_o` = 0.
    - Else if `cnt` != 0: decrement `cnt`.
    - Else sample `y_i`: `exp = ~((vec[0]&vec[1]) | (vec[2]&vec[3]))`. If `y_i != exp`, increment `err_cnt_o`; if `first_err_vld_o` = 0, set it and load `first_err_vec_o` = `vec`.
    - Then, if `vec` == 15, go to DONE. Otherwise increment `vec` and reload `cnt` = SETTLE_CYCLES−1.
  - DONE: `done_o` = 1 and `vec` holds 15. `start_i` behaves as in IDLE and clears `done_o` on the accepting edge; `abort_i` is ignored.
- `start_i` in RUN is ignored. `start_i` and `abort_i` asserted together in IDLE/DONE: no start.
- When `cke_i` = 0, nothing changes, including the sample; inputs seen in that cycle are dropped.

## Timing
- Reset values: all outputs 0, `vec` = 0, `cnt` = 0, state IDLE. Reset takes effect immediately, mid-sweep included, and discards results.
- A start accepted at edge t places vector 0 on `a_o`..`d_o` after edge t.
- Vector k is presented for exactly SETTLE_CYCLES enabled cycles. `y_i` is sampled on the last of those edges, which also advances to k+1.
- Total run time: 16×SETTLE_CYCLES enabled cycles from the accepting edge to the edge that sets `done_o`. `busy_o` falls on that same edge.
- The gate under test must settle within SETTLE_CYCLES−1 cycles plus one cycle of combinational path. With SETTLE_CYCLES = 1, `y_i` is sampled one cycle after the vector changes.
- Abort: `busy_o` = 0 on the edge after `abort_i` is sampled.

## Test plan
- Reset mid-sweep (`arst_i` pulsed at vector 6, between edges) → all outputs 0 asynchronously; state IDLE afterwards.
- Real `iob_aoi` attached, SETTLE_CYCLES = 2, `start_i` pulse → `busy_o` high 32 cycles, then `done_o` = 1, `pass_o` = 1, `err_cnt_o` = 0, `first_err_vld_o` = 0, `a_o`..`d_o` = 1111.
- `y_i` tied to 1 → `err_cnt_o` = 7, `first_err_vec_o` = 0011, `first_err_vld_o` = 1, `pass_o` = 0.
- `y_i` = `(a&b)|(c&d)` (inverted gate), SETTLE_CYCLES = 1 → `err_cnt_o` = 16, `first_err_vec_o` = 0000, done 16 cycles after start.
- `abort_i` while vector 5 is presented → `busy_o` = 0 the next cycle, `done_o` = 0, `a_o`..`d_o` = 0101. `start_i` and `abort_i` together in IDLE → stays IDLE. A restart then clears the counts.
- `cke_i` low for 10 cycles mid-sweep, real gate, SETTLE_CYCLES = 2 → done after 42 cycles, `pass_o` = 1. `start_i` pulsed during RUN → ignored, count unchanged.
